// File: rtl/clock_ctrl.sv
// Time-of-day controller: chained sec/min/hr counters with a set-mode FSM and an alarm.
// Reset is synchronous and active-high. All outputs are registered.
module clock_ctrl #(
  parameter int unsigned SEC_MOD = 60,
  parameter int unsigned MIN_MOD = 60,
  parameter int unsigned HR_MOD  = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       alarm_en,
  output logic [6:0] sec,
  output logic [6:0] min,
  output logic [6:0] hr,
  output logic [6:0] al_min,
  output logic [6:0] al_hr,
  output logic [2:0] mode,
  output logic       day_pulse,
  output logic       buzz
);

  localparam logic [6:0] SecMax = 7'(SEC_MOD - 1);
  localparam logic [6:0] MinMax = 7'(MIN_MOD - 1);
  localparam logic [6:0] HrMax  = 7'(HR_MOD - 1);

  typedef enum logic [2:0] {
    StRun      = 3'd0,
    StSetHr    = 3'd1,
    StSetMin   = 3'd2,
    StSetAlHr  = 3'd3,
    StSetAlMin = 3'd4
  } state_e;

  state_e state_q, state_d;
  logic   mode_btn_q, inc_btn_q;
  logic   dismiss_q, dismiss_d;
  logic   mode_p, inc_p;
  logic   time_runs, time_hits, match;
  logic   sec_wrap, min_wrap, hr_wrap;
  logic   al_min_wrap, al_hr_wrap;

  always_comb begin
    mode_p      = mode_btn & ~mode_btn_q;
    // A simultaneous mode press swallows the increment.
    inc_p       = inc_btn & ~inc_btn_q & ~mode_p;
    time_runs   = (state_q == StRun) || (state_q == StSetAlHr) || (state_q == StSetAlMin);
    sec_wrap    = (sec == SecMax);
    min_wrap    = (min == MinMax);
    hr_wrap     = (hr == HrMax);
    al_min_wrap = (al_min == MinMax);
    al_hr_wrap  = (al_hr == HrMax);
    time_hits   = (hr == al_hr) && (min == al_min);
    match       = alarm_en && time_hits && (state_q == StRun);

    dismiss_d = dismiss_q;
    if (!alarm_en || !time_hits) begin
      dismiss_d = 1'b0;
    end else if (inc_p && buzz && (state_q == StRun)) begin
      dismiss_d = 1'b1;
    end

    state_d = state_q;
    if (mode_p) begin
      unique case (state_q)
        StRun:      state_d = StSetHr;
        StSetHr:    state_d = StSetMin;
        StSetMin:   state_d = StSetAlHr;
        StSetAlHr:  state_d = StSetAlMin;
        StSetAlMin: state_d = StRun;
        default:    state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      mode_btn_q <= 1'b0;
      inc_btn_q  <= 1'b0;
      dismiss_q  <= 1'b0;
      sec        <= 7'd0;
      min        <= 7'd0;
      hr         <= 7'd0;
      al_min     <= 7'd0;
      al_hr      <= 7'd0;
      day_pulse  <= 1'b0;
      buzz       <= 1'b0;
    end else begin
      mode_btn_q <= mode_btn;
      inc_btn_q  <= inc_btn;
      dismiss_q  <= dismiss_d;
      buzz       <= match & ~dismiss_d;
      day_pulse  <= 1'b0;
      state_q    <= state_d;

      if (time_runs && tick) begin
        if (sec_wrap) begin
          sec <= 7'd0;
          if (min_wrap) begin
            min <= 7'd0;
            if (hr_wrap) begin
              hr        <= 7'd0;
              day_pulse <= 1'b1;
            end else begin
              hr <= hr + 7'd1;
            end
          end else begin
            min <= min + 7'd1;
          end
        end else begin
          sec <= sec + 7'd1;
        end
      end

      if (inc_p) begin
        unique case (state_q)
          StSetHr:    hr     <= hr_wrap ? 7'd0 : hr + 7'd1;
          StSetMin:   min    <= min_wrap ? 7'd0 : min + 7'd1;
          StSetAlHr:  al_hr  <= al_hr_wrap ? 7'd0 : al_hr + 7'd1;
          StSetAlMin: al_min <= al_min_wrap ? 7'd0 : al_min + 7'd1;
          default:    ;
        endcase
      end

      // Entering time-set mode starts the new time at :00 seconds.
      if (mode_p && (state_q == StRun)) begin
        sec <= 7'd0;
      end
    end
  end

  assign mode = state_q;

endmodule
